// File: rtl/rib_mem_arbiter.sv
// Two-master (data, fetch) to one-slave RIB memory arbiter: fixed data priority with
// a fetch anti-starvation streak counter and a per-transaction slave timeout.
module rib_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            d_req_i,
  input  logic                            d_we_i,
  input  logic [AW-1:0]                   d_addr_i,
  input  logic [DW-1:0]                   d_wdata_i,
  output logic [DW-1:0]                   d_rdata_o,
  output logic                            d_ready_o,
  input  logic                            i_req_i,
  input  logic [AW-1:0]                   i_addr_i,
  output logic [DW-1:0]                   i_rdata_o,
  output logic                            i_ready_o,
  output logic                            s_req_o,
  output logic                            s_we_o,
  output logic [AW-1:0]                   s_addr_o,
  output logic [DW-1:0]                   s_wdata_o,
  input  logic [DW-1:0]                   s_rdata_i,
  input  logic                            s_ready_i,
  output logic                            err_o,
  output logic                            fetch_stall_o,
  output logic [1:0]                      dbg_state_o,
  output logic [$clog2(MAX_STREAK+1)-1:0] dbg_streak_o
);
  // Handshake: a master holds req/addr/we/wdata stable until its one-cycle ready;
  // the slave sees a registered request held constant until s_ready_i or timeout.
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            busy, abort, done, streak_full;

  assign busy        = (state_q != IDLE);
  assign abort       = busy && !s_ready_i && (tcnt_q == TW'(TIMEOUT - 1));
  assign done        = busy && (s_ready_i || abort);
  assign streak_full = (streak_q == SW'(MAX_STREAK));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      streak_q <= '0;
      tcnt_q   <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tcnt_q   <= tcnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    tcnt_d   = tcnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (!i_req_i) streak_d = '0;
        // A starved fetch overrides data priority once the streak is exhausted.
        if (i_req_i && streak_full) begin
          state_d  = BUSY_I;
          streak_d = '0;
          addr_d   = i_addr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
        end else if (d_req_i) begin
          state_d = BUSY_D;
          addr_d  = d_addr_i;
          we_d    = d_we_i;
          wdata_d = d_wdata_i;
          if (i_req_i && !streak_full) streak_d = streak_q + 1'b1;
        end else if (i_req_i) begin
          state_d  = BUSY_I;
          streak_d = '0;
          addr_d   = i_addr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
        end
      end
      default: begin
        if (done) state_d = IDLE;
        else      tcnt_d  = tcnt_q + 1'b1;
      end
    endcase
  end

  assign s_req_o       = busy;
  assign s_we_o        = we_q;
  assign s_addr_o      = addr_q;
  assign s_wdata_o     = wdata_q;
  assign err_o         = abort;
  assign d_ready_o     = done && (state_q == BUSY_D);
  assign i_ready_o     = done && (state_q == BUSY_I);
  assign d_rdata_o     = (state_q == BUSY_D && s_ready_i) ? s_rdata_i : '0;
  assign i_rdata_o     = (state_q == BUSY_I && s_ready_i) ? s_rdata_i : '0;
  assign fetch_stall_o = i_req_i && !i_ready_o;
  assign dbg_state_o   = state_q;
  assign dbg_streak_o  = streak_q;

endmodule

// File: tb/tb_rib_mem_arbiter.sv
// Self-checking bench for rib_mem_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-level arbitration model.
module tb_rib_mem_arbiter;
  localparam int MS  = 4;
  localparam int TMO = 8;

  logic        clk_i, rst_ni;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        d_ready_o;
  logic        i_req_i;
  logic [31:0] i_addr_i, i_rdata_o;
  logic        i_ready_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic        s_ready_i, err_o, fetch_stall_o;
  logic [1:0]  dbg_state_o;
  logic [2:0]  dbg_streak_o;

  int checks = 0;
  int errors = 0;

  rib_mem_arbiter #(.AW(32), .DW(32), .MAX_STREAK(MS), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ready_o(i_ready_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
    .err_o(err_o), .fetch_stall_o(fetch_stall_o),
    .dbg_state_o(dbg_state_o), .dbg_streak_o(dbg_streak_o)
  );

  // Clock and watchdog
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet_cycle();
    @(negedge clk_i);
    d_req_i   = 1'b0;
    i_req_i   = 1'b0;
    s_ready_i = 1'b0;
    #1;
  endtask

  int          streak_m;
  bit          d_pend, i_pend, win_i, fin;
  int          r;
  logic [31:0] exp_addr, exp_wdata, rd;
  logic        exp_we;
  logic [9:0]  grant_pat;

  initial begin
    // Reset
    rst_ni = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    i_req_i = 1'b1; i_addr_i = '0; s_rdata_i = 32'h1234_5678; s_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    chk_b("rst_s_req", s_req_o, 1'b0);
    chk_b("rst_d_ready", d_ready_o, 1'b0);
    chk_b("rst_i_ready", i_ready_o, 1'b0);
    chk_b("rst_err", err_o, 1'b0);
    chk_w("rst_s_addr", s_addr_o, 32'h0);
    chk_w("rst_d_rdata", d_rdata_o, 32'h0);
    chk_b("rst_stall", fetch_stall_o, 1'b1);
    chk_w("rst_state", 32'(dbg_state_o), 32'd0);
    chk_w("rst_streak", 32'(dbg_streak_o), 32'd0);
    @(negedge clk_i);
    i_req_i = 1'b0; s_ready_i = 1'b0; rst_ni = 1'b1;

    // Single data write, zero-wait slave
    @(negedge clk_i);
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h1000_0004; d_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk_b("wr_c0_s_req", s_req_o, 1'b0);
    @(negedge clk_i);
    s_ready_i = 1'b1;
    #1;
    chk_b("wr_c1_s_req", s_req_o, 1'b1);
    chk_b("wr_c1_s_we", s_we_o, 1'b1);
    chk_w("wr_c1_s_addr", s_addr_o, 32'h1000_0004);
    chk_w("wr_c1_s_wdata", s_wdata_o, 32'hDEAD_BEEF);
    chk_b("wr_c1_d_ready", d_ready_o, 1'b1);
    chk_b("wr_c1_i_ready", i_ready_o, 1'b0);
    quiet_cycle();
    chk_w("wr_c2_state", 32'(dbg_state_o), 32'd0);
    chk_b("wr_c2_s_req", s_req_o, 1'b0);

    // Fetch read with three slave wait cycles
    @(negedge clk_i);
    i_req_i = 1'b1; i_addr_i = 32'h0000_0100; s_rdata_i = 32'hFFFF_FFFF;
    #1;
    chk_b("rd_c0_stall", fetch_stall_o, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      #1;
      chk_b("rd_wait_stall", fetch_stall_o, 1'b1);
      chk_b("rd_wait_i_ready", i_ready_o, 1'b0);
      chk_b("rd_wait_s_req", s_req_o, 1'b1);
      chk_w("rd_wait_s_addr", s_addr_o, 32'h0000_0100);
      chk_b("rd_wait_s_we", s_we_o, 1'b0);
    end
    @(negedge clk_i);
    s_ready_i = 1'b1; s_rdata_i = 32'h0000_0013;
    #1;
    chk_b("rd_c4_i_ready", i_ready_o, 1'b1);
    chk_w("rd_c4_i_rdata", i_rdata_o, 32'h0000_0013);
    chk_b("rd_c4_stall", fetch_stall_o, 1'b0);
    chk_w("rd_c4_d_rdata", d_rdata_o, 32'h0);
    chk_b("rd_c4_d_ready", d_ready_o, 1'b0);
    quiet_cycle();

    // Both masters held continuously, zero-wait slave
    @(negedge clk_i);
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2000_0000; i_req_i = 1'b1; i_addr_i = 32'h40;
    s_ready_i = 1'b1;
    streak_m = 0;
    grant_pat = '0;
    for (int n = 0; n < 10; n++) begin
      if (n != 0) @(negedge clk_i);
      #1;
      chk_b("sim_idle_s_req", s_req_o, 1'b0);
      win_i = (streak_m == MS);
      streak_m = win_i ? 0 : ((streak_m < MS) ? streak_m + 1 : MS);
      @(negedge clk_i);
      s_rdata_i = 32'(n);
      #1;
      chk_b("sim_d_ready", d_ready_o, !win_i);
      chk_b("sim_i_ready", i_ready_o, win_i);
      chk_w("sim_streak", 32'(dbg_streak_o), 32'(streak_m));
      grant_pat[n] = i_ready_o;
    end
    chk_w("sim_grant_order", 32'(grant_pat), 32'h210);
    quiet_cycle();

    // Timeout abort on a dead slave, then a late ready is ignored
    @(negedge clk_i);
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h3000_0000; s_rdata_i = 32'hABCD_0000;
    for (int c = 1; c < TMO; c++) begin
      @(negedge clk_i);
      #1;
      chk_b("tmo_wait_d_ready", d_ready_o, 1'b0);
      chk_b("tmo_wait_err", err_o, 1'b0);
    end
    @(negedge clk_i);
    #1;
    chk_b("tmo_abort_d_ready", d_ready_o, 1'b1);
    chk_b("tmo_abort_err", err_o, 1'b1);
    chk_w("tmo_abort_d_rdata", d_rdata_o, 32'h0);
    quiet_cycle();
    chk_b("tmo_after_s_req", s_req_o, 1'b0);
    @(negedge clk_i);
    s_ready_i = 1'b1;
    #1;
    chk_b("tmo_late_d_ready", d_ready_o, 1'b0);
    chk_b("tmo_late_i_ready", i_ready_o, 1'b0);
    quiet_cycle();

    // Slave ready exactly on the abort cycle wins
    @(negedge clk_i);
    d_req_i = 1'b1; d_addr_i = 32'h3000_0010;
    for (int c = 1; c < TMO; c++) @(negedge clk_i);
    @(negedge clk_i);
    s_ready_i = 1'b1; s_rdata_i = 32'h55;
    #1;
    chk_b("bnd_d_ready", d_ready_o, 1'b1);
    chk_w("bnd_d_rdata", d_rdata_o, 32'h55);
    chk_b("bnd_err", err_o, 1'b0);
    quiet_cycle();

    // Asynchronous reset in the middle of a fetch
    @(negedge clk_i);
    i_req_i = 1'b1; i_addr_i = 32'h0000_0200;
    @(negedge clk_i);
    #1;
    chk_b("rst_mid_busy_s_req", s_req_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_b("rst_mid_s_req", s_req_o, 1'b0);
    chk_b("rst_mid_i_ready", i_ready_o, 1'b0);
    chk_b("rst_mid_stall", fetch_stall_o, 1'b1);
    @(negedge clk_i);
    i_req_i = 1'b0; d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h5000_0008; d_wdata_i = 32'hCAFE;
    rst_ni = 1'b1;
    #1;
    chk_w("rst_rel_state", 32'(dbg_state_o), 32'd0);
    chk_w("rst_rel_streak", 32'(dbg_streak_o), 32'd0);
    @(negedge clk_i);
    s_ready_i = 1'b1;
    #1;
    chk_w("rst_rel_served_state", 32'(dbg_state_o), 32'd1);
    chk_w("rst_rel_served_addr", s_addr_o, 32'h5000_0008);
    chk_b("rst_rel_d_ready", d_ready_o, 1'b1);
    quiet_cycle();

    // Randomized traffic against the transaction-level model
    d_pend = 0; i_pend = 0; streak_m = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_i);
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; d_we_i = 1'($urandom_range(0, 1)); d_addr_i = $urandom; d_wdata_i = $urandom;
      end
      if (!i_pend && $urandom_range(0, 2) != 0) begin
        i_pend = 1; i_addr_i = $urandom;
      end
      d_req_i = d_pend; i_req_i = i_pend;
      s_ready_i = ($urandom_range(0, 3) == 0); s_rdata_i = $urandom;
      #1;
      chk_w("rnd_idle_streak", 32'(dbg_streak_o), 32'(streak_m));
      chk_b("rnd_idle_s_req", s_req_o, 1'b0);
      chk_b("rnd_idle_d_ready", d_ready_o, 1'b0);
      chk_b("rnd_idle_i_ready", i_ready_o, 1'b0);
      chk_b("rnd_idle_err", err_o, 1'b0);
      chk_b("rnd_idle_stall", fetch_stall_o, i_pend);
      if (i_pend && streak_m == MS) begin
        win_i = 1; streak_m = 0;
      end else if (d_pend) begin
        win_i = 0; streak_m = i_pend ? ((streak_m < MS) ? streak_m + 1 : MS) : 0;
      end else if (i_pend) begin
        win_i = 1; streak_m = 0;
      end else begin
        streak_m = 0;
        continue;
      end
      exp_addr  = win_i ? i_addr_i : d_addr_i;
      exp_we    = win_i ? 1'b0 : d_we_i;
      exp_wdata = win_i ? 32'h0 : d_wdata_i;
      r = $urandom_range(1, TMO + 2);
      for (int k = 1; k <= TMO; k++) begin
        @(negedge clk_i);
        s_ready_i = (k == r); rd = $urandom; s_rdata_i = rd;
        #1;
        fin = (k == r) || (k == TMO);
        chk_b("rnd_s_req", s_req_o, 1'b1);
        chk_w("rnd_s_addr", s_addr_o, exp_addr);
        chk_b("rnd_s_we", s_we_o, exp_we);
        chk_w("rnd_s_wdata", s_wdata_o, exp_wdata);
        chk_b("rnd_d_ready", d_ready_o, fin && !win_i);
        chk_b("rnd_i_ready", i_ready_o, fin && win_i);
        chk_b("rnd_err", err_o, fin && (k != r));
        chk_w("rnd_d_rdata", d_rdata_o, (fin && !win_i && k == r) ? rd : 32'h0);
        chk_w("rnd_i_rdata", i_rdata_o, (fin && win_i && k == r) ? rd : 32'h0);
        chk_b("rnd_stall", fetch_stall_o, i_pend && !(fin && win_i));
        if (fin) begin
          if (win_i) i_pend = 0;
          else       d_pend = 0;
          break;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
